// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-0 slave turning rw/addr/data frames into register strobes
module spi_slave_responder #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck_i,
    input  logic              ss_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_t,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_err
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        sck_sync;
    logic [2:0]        ss_sync;
    logic [1:0]        mosi_sync;
    logic [1:0]        warm;
    logic              armed;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W:0]   cmd_sr;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic              load_tx;
    logic              sck_rise, sck_fall, ss_fall, ss_rise, mosi_bit;

    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign ss_rise  = ss_sync[1] & ~ss_sync[2];
    // A select held low through reset release would look like a fall; only arm after a real high.
    assign ss_fall  = armed & ~ss_sync[1] & ss_sync[2];
    assign mosi_bit = mosi_sync[1];
    assign miso_t   = ss_sync[1];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ss_fall) state_nxt = CMD;
            CMD: begin
                if (ss_rise) state_nxt = IDLE;
                else if (sck_rise && bit_cnt == CMD_LAST) state_nxt = DATA;
            end
            DATA: begin
                if (ss_rise) state_nxt = IDLE;
                else if (sck_rise && bit_cnt == DATA_LAST) state_nxt = DONE;
            end
            DONE: if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            warm      <= '0;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            load_tx   <= 1'b0;
            miso_o    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[1:0], sck_i};
            ss_sync   <= {ss_sync[1:0], ss_n_i};
            mosi_sync <= {mosi_sync[0], mosi_i};
            warm      <= {warm[0], 1'b1};
            armed     <= armed | (warm[1] & ss_sync[1]);
            wr_en     <= 1'b0;
            rd_req    <= 1'b0;
            frame_err <= 1'b0;
            // rd_data is valid the cycle after rd_req; load it at the end of that cycle.
            load_tx   <= rd_req;
            if (load_tx) tx_sr <= rd_data;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    miso_o  <= 1'b0;
                end
                CMD: begin
                    miso_o <= 1'b0;
                    if (ss_rise) begin
                        frame_err <= 1'b1;
                    end else if (sck_rise) begin
                        cmd_sr <= {cmd_sr[ADDR_W-1:0], mosi_bit};
                        if (bit_cnt == CMD_LAST) begin
                            bit_cnt <= '0;
                            if (cmd_sr[ADDR_W-1]) begin
                                rd_req  <= 1'b1;
                                rd_addr <= {cmd_sr[ADDR_W-2:0], mosi_bit};
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (ss_rise) begin
                        frame_err <= 1'b1;
                    end else begin
                        if (sck_rise) begin
                            rx_sr   <= {rx_sr[DATA_W-3:0], mosi_bit};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == DATA_LAST && !cmd_sr[ADDR_W]) begin
                                wr_en   <= 1'b1;
                                wr_addr <= cmd_sr[ADDR_W-1:0];
                                wr_data <= {rx_sr, mosi_bit};
                            end
                        end
                        if (sck_fall) begin
                            if (cmd_sr[ADDR_W]) begin
                                miso_o <= tx_sr[DATA_W-1];
                                tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                            end else begin
                                miso_o <= 1'b0;
                            end
                        end
                    end
                end
                DONE: miso_o <= 1'b0;
                default: miso_o <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - randomized self-checking bench for spi_slave_responder
`timescale 1ns/1ps
module tb_spi_slave_responder;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 16;
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int HALF    = 4;

    logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic miso_o, miso_t, wr_en, rd_req, busy, frame_err;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data = '0;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    spi_slave_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .sck_i(sck), .ss_n_i(ss_n), .mosi_i(mosi),
        .miso_o(miso_o), .miso_t(miso_t), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .frame_err(frame_err)
    );

    logic [DATA_W-1:0]        mem [1<<ADDR_W];
    logic [ADDR_W+DATA_W-1:0] exp_wr [$];
    logic [ADDR_W-1:0]        exp_rd [$];
    int                       exp_ferr = 0;
    int                       wr_seen = 0, rd_seen = 0, ferr_seen = 0;
    logic [ADDR_W-1:0]        last_wr_addr = '0, last_rd_addr = '0;
    logic [DATA_W-1:0]        last_wr_data = '0;
    logic [ADDR_W-1:0]        cap_wr_addr = '0, cap_rd_addr = '0;
    logic [DATA_W-1:0]        cap_wr_data = '0;
    logic [ADDR_W+DATA_W-1:0] e_wr;
    logic [ADDR_W-1:0]        e_rd;
    logic [3:0]               ss_hist = 4'hF;
    int                       rst_run = 0;
    logic                     trk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Per-cycle comparison against the transaction-level model queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_miso_o", 32'(miso_o), 32'd0);
            check("rst_miso_t", 32'(miso_t), 32'd1);
            check("rst_wr_en", 32'(wr_en), 32'd0);
            check("rst_wr_addr", 32'(wr_addr), 32'd0);
            check("rst_wr_data", 32'(wr_data), 32'd0);
            check("rst_rd_req", 32'(rd_req), 32'd0);
            check("rst_rd_addr", 32'(rd_addr), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_frame_err", 32'(frame_err), 32'd0);
            last_wr_addr = '0; last_wr_data = '0; last_rd_addr = '0;
            rst_run = 0; trk = 1'b0;
        end else begin
            if (rst_run >= 3) check("miso_t", 32'(miso_t), 32'(ss_hist[1]));
            if (rst_run >= 4 && ss_hist[2]) trk = 1'b1;
            if (trk) check("busy", 32'(busy), 32'(!ss_hist[2]));
            if (wr_en) begin
                wr_seen++; cap_wr_addr = wr_addr; cap_wr_data = wr_data;
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_en: unexpected strobe addr=%0h data=%0h at %0t", wr_addr, wr_data, $time);
                end else begin
                    e_wr = exp_wr.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e_wr[ADDR_W+DATA_W-1:DATA_W]));
                    check("wr_data", 32'(wr_data), 32'(e_wr[DATA_W-1:0]));
                    last_wr_addr = e_wr[ADDR_W+DATA_W-1:DATA_W];
                    last_wr_data = e_wr[DATA_W-1:0];
                end
            end else begin
                check("wr_addr_hold", 32'(wr_addr), 32'(last_wr_addr));
                check("wr_data_hold", 32'(wr_data), 32'(last_wr_data));
            end
            if (rd_req) begin
                rd_seen++; cap_rd_addr = rd_addr;
                if (exp_rd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_req: unexpected request addr=%0h at %0t", rd_addr, $time);
                end else begin
                    e_rd = exp_rd.pop_front();
                    check("rd_addr", 32'(rd_addr), 32'(e_rd));
                    last_rd_addr = e_rd;
                end
            end else begin
                check("rd_addr_hold", 32'(rd_addr), 32'(last_rd_addr));
            end
            if (frame_err) begin
                ferr_seen++; total++;
                if (exp_ferr == 0) begin
                    bad++;
                    $display("FAIL frame_err: unexpected pulse at %0t", $time);
                end else begin
                    exp_ferr--;
                end
            end
            if (rst_run < 100) rst_run++;
        end
        ss_hist = {ss_hist[2:0], ss_n};
    end

    // Register file side: garbage on the rd_req cycle, the addressed word only on the cycle after.
    initial begin
        logic pend;
        logic [ADDR_W-1:0] a;
        pend = 1'b0; a = '0;
        forever begin
            @(posedge clk); #1;
            if (pend) rd_data = mem[a];
            else rd_data = DATA_W'($urandom);
            pend = rd_req; a = rd_addr;
        end
    end

    // One select window of nbits SCK pulses; rst_at >= 0 pulses reset before that bit.
    task automatic run_frame(input logic [FRAME_W-1:0] f, input int nbits, input int rst_at,
                             output logic [DATA_W-1:0] rx);
        logic rw;
        logic [ADDR_W-1:0] addr;
        logic em;
        rw   = f[FRAME_W-1];
        addr = f[FRAME_W-2 -: ADDR_W];
        rx   = '0;
        if (rst_at < 0) begin
            if (nbits >= FRAME_W && !rw) exp_wr.push_back({addr, f[DATA_W-1:0]});
            if (rw && nbits >= 1 + ADDR_W) exp_rd.push_back(addr);
            if (nbits < FRAME_W) exp_ferr++;
        end
        ss_n = 1'b0;
        tick(2);
        for (int b = 0; b < nbits; b++) begin
            if (b == rst_at) begin
                check("busy_before_rst", 32'(busy), 32'd1);
                rst_n = 1'b0;
                #1;
                check("async_rst_busy", 32'(busy), 32'd0);
                check("async_rst_miso_t", 32'(miso_t), 32'd1);
                check("async_rst_wr_addr", 32'(wr_addr), 32'd0);
                check("async_rst_wr_data", 32'(wr_data), 32'd0);
                check("async_rst_rd_addr", 32'(rd_addr), 32'd0);
                tick(3);
                rst_n = 1'b1;
            end
            em = 1'b0;
            if (rst_at < 0 && rw && b >= 1 + ADDR_W && b < FRAME_W) em = mem[addr][FRAME_W-1-b];
            mosi = (b < FRAME_W) ? f[FRAME_W-1-b] : 1'($urandom);
            tick(HALF);
            check($sformatf("miso_bit%0d", b), 32'(miso_o), 32'(em));
            if (b >= 1 + ADDR_W && b < FRAME_W) rx = {rx[DATA_W-2:0], miso_o};
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
        tick(HALF);
        ss_n = 1'b1;
        tick(6 + $urandom_range(0, 4));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] rx;
        logic [FRAME_W-1:0] f;
        int w0, r0, f0, nb, sel;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
        mem[1] = 16'h1234;
        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(10);
        check("idle_miso_t", 32'(miso_t), 32'd1);

        f0 = ferr_seen;
        exp_ferr++;
        ss_n = 1'b0;
        tick(3);
        check("sel_miso_t_3clk", 32'(miso_t), 32'd0);
        tick(3);
        ss_n = 1'b1;
        tick(8);
        check("empty_frame_err", 32'(ferr_seen - f0), 32'd1);

        w0 = wr_seen; r0 = rd_seen; f0 = ferr_seen;
        run_frame(24'h05A5C3, 24, -1, rx);
        check("w40_count", 32'(wr_seen - w0), 32'd1);
        check("w40_addr", 32'(cap_wr_addr), 32'h05);
        check("w40_data", 32'(cap_wr_data), 32'hA5C3);
        check("w40_no_rd", 32'(rd_seen - r0), 32'd0);
        check("w40_no_err", 32'(ferr_seen - f0), 32'd0);

        w0 = wr_seen; r0 = rd_seen;
        run_frame(24'h810000, 24, -1, rx);
        check("r41_count", 32'(rd_seen - r0), 32'd1);
        check("r41_addr", 32'(cap_rd_addr), 32'h01);
        check("r41_miso_word", 32'(rx), 32'h1234);
        check("r41_no_wr", 32'(wr_seen - w0), 32'd0);

        w0 = wr_seen; f0 = ferr_seen;
        run_frame(24'h3C5A5A, 12, -1, rx);
        check("a42_err", 32'(ferr_seen - f0), 32'd1);
        check("a42_no_wr", 32'(wr_seen - w0), 32'd0);
        run_frame(24'h7FFFFF, 24, -1, rx);
        check("a42_next_addr", 32'(cap_wr_addr), 32'h7F);
        check("a42_next_data", 32'(cap_wr_data), 32'hFFFF);

        w0 = wr_seen;
        run_frame(24'h020001, 28, -1, rx);
        check("x43_count", 32'(wr_seen - w0), 32'd1);
        check("x43_addr", 32'(cap_wr_addr), 32'h02);
        check("x43_data", 32'(cap_wr_data), 32'h0001);

        w0 = wr_seen; f0 = ferr_seen;
        run_frame(24'h1BBEEF, 24, 20, rx);
        check("r45_no_wr", 32'(wr_seen - w0), 32'd0);
        check("r45_no_err", 32'(ferr_seen - f0), 32'd0);
        run_frame(24'h112233, 24, -1, rx);
        check("r45_next_addr", 32'(cap_wr_addr), 32'h11);
        check("r45_next_data", 32'(cap_wr_data), 32'h2233);

        for (int n = 0; n < 40; n++) begin
            f = FRAME_W'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 6) nb = FRAME_W;
            else if (sel < 8) nb = FRAME_W + $urandom_range(1, 6);
            else nb = $urandom_range(0, FRAME_W - 1);
            run_frame(f, nb, -1, rx);
        end

        tick(10);
        check("left_wr", 32'(exp_wr.size()), 32'd0);
        check("left_rd", 32'(exp_rd.size()), 32'd0);
        check("left_ferr", 32'(exp_ferr), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_responder.md
SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 Parameter ADDR_W, default 7, register address width.
REQ-002 Parameter DATA_W, default 16, register data width; frame length FRAME_W = 1+ADDR_W+DATA_W (24 by default).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; SHALL run at least 8x SCK frequency.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sck_i  input  1  SPI clock from the IOBUF O pin; asynchronous to clk.
REQ-007 ss_n_i  input  1  slave select, active-low; asynchronous to clk.
REQ-008 mosi_i  input  1  master-out data; asynchronous to clk.
REQ-009 miso_o  output  1  slave-out data, to the IOBUF I pin.
REQ-010 miso_t  output  1  tristate control, to the IOBUF T pin: 1 = high-Z, 0 = drive.
REQ-011 wr_en  output  1  one-cycle write strobe.
REQ-012 wr_addr  output  ADDR_W  write address; valid while wr_en=1.
REQ-013 wr_data  output  DATA_W  write data; valid while wr_en=1.
REQ-014 rd_req  output  1  one-cycle read request.
REQ-015 rd_addr  output  ADDR_W  read address; valid while rd_req=1.
REQ-016 rd_data  input  DATA_W  read data; SHALL be valid on the cycle after rd_req.
REQ-017 busy  output  1  high while a frame is in progress.
REQ-018 frame_err  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-019 sck_i, ss_n_i and mosi_i SHALL each pass through a 2-FF synchronizer; edges SHALL be detected on the synchronized signals with a third register.
REQ-020 SPI mode 0 (CPOL=0, CPHA=0), MSB first: MOSI sampled on detected SCK rise; MISO updated on detected SCK fall.
REQ-021 Frame = rw bit (1 = read), then ADDR_W address bits, then DATA_W data bits.
REQ-022 FSM states: IDLE, CMD, DATA, DONE.
REQ-023 IDLE -> CMD on synchronized ss_n falling edge; bit counter cleared to 0; busy=1.
REQ-024 CMD: shift in one bit per SCK rise; after bit index ADDR_W (8th rise by default) -> DATA.
REQ-025 On the CMD->DATA transition with rw=1, rd_req SHALL pulse on the next clk, with rd_addr = captured address.
REQ-026 On the cycle after rd_req, rd_data SHALL be loaded into the TX shift register.
REQ-027 MISO during CMD = 0; the data MSB is driven from the first SCK fall after the CMD->DATA transition; each following fall shifts out the next bit.
REQ-028 With rw=0, MISO SHALL drive 0 for the whole frame.
REQ-029 DATA: after the DATA_W-th data rise -> DONE; for rw=0, wr_en SHALL pulse on the next clk, with the captured wr_addr/wr_data.
REQ-030 rw=1 frames SHALL NOT assert wr_en; MOSI data bits are ignored.
REQ-031 DONE: further SCK edges are ignored, miso_o=0; DONE -> IDLE on ss_n rise; busy drops the same cycle.
REQ-032 ss_n rise while in CMD or DATA: frame_err pulses for one cycle, no wr_en, state -> IDLE.
REQ-033 A read already requested is not cancelled by a later abort; its data is discarded.
REQ-034 miso_t = synchronized ss_n; high-Z whenever deselected.
REQ-035 An ss_n fall in the same cycle as a frame's ss_n rise is not possible (both come from one synchronizer); after any return to IDLE, a new ss_n fall starts a fresh frame.
REQ-036 wr_addr, wr_data and rd_addr SHALL hold their last values between strobes.

Reset
REQ-037 On rst_n=0, asynchronously: state=IDLE, counter=0, shift registers=0, synchronizer flops=1 for ss_n and 0 for sck/mosi.
REQ-038 Reset outputs: miso_o=0, miso_t=1, wr_en=0, wr_addr=0, wr_data=0, rd_req=0, rd_addr=0, busy=0, frame_err=0.
REQ-039 Reset mid-frame discards the frame with no strobes; after reset release, the block waits for a new ss_n fall.

Verification
REQ-040 Write frame 0x05_A5C3 (rw=0, addr 0x05) -> exactly one wr_en, with wr_addr=0x05, wr_data=0xA5C3; no rd_req; frame_err=0.
REQ-041 Read frame 0x81_0000, rd_data=0x1234 driven one cycle after rd_req -> rd_addr=0x01; MISO bits during the 16 data bits = 0x1234 MSB first; wr_en never asserted.
REQ-042 ss_n deasserted after 12 bits of a write -> frame_err pulses once; no wr_en; a following full write 0x7F_FFFF gives wr_addr=0x7F, wr_data=0xFFFF.
REQ-043 28 SCK pulses in one select window of write 0x02_0001 -> a single wr_en (addr 0x02, data 0x0001); the 4 extra bits are ignored.
REQ-044 Idle bus with ss_n=1 -> miso_t=1 always; ss_n=0 -> miso_t=0 within 3 clk.
REQ-045 rst_n pulsed low at bit 20 of a write -> all outputs at reset values immediately; no wr_en; the next frame decodes correctly.
